// File: rtl/dds_wave_gen.sv
// Direct-digital-synthesis oscillator: phase accumulator with a glitch-free
// retune handshake, quarter-wave sine ROM and saw/square/triangle generators.
module dds_wave_gen #(
  parameter int OUT_W   = 8,
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic               ftw_load,
  input  logic [1:0]         mode,
  output logic [OUT_W-1:0]   sig,
  output logic               sig_valid,
  output logic               wrap
);

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_TRI    = 2'd3
  } mode_t;

  localparam int             N    = (1 << LUT_AW) + 1;
  localparam int             AMP  = (1 << (OUT_W - 1)) - 1;
  localparam logic [OUT_W-1:0] MID = OUT_W'(1 << (OUT_W - 1));
  localparam logic [LUT_AW:0]  QTR = {1'b1, {LUT_AW{1'b0}}};

  // round(AMP * sin(pi/2 * x / 2^LUT_AW)) using a 2^28 fixed-point Taylor series,
  // so the table elaborates from constants without any real arithmetic.
  function automatic int quarter_sine(input int x);
    longint theta, theta2, term, sum;
    theta  = (longint'(421657428) * longint'(x)) >>> LUT_AW;
    theta2 = (theta * theta) >>> 28;
    term   = theta;
    sum    = theta;
    for (int k = 1; k <= 12; k++) begin
      term = -((term * theta2) >>> 28) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return int'((longint'(AMP) * sum + (longint'(1) << 27)) >>> 28);
  endfunction

  logic [OUT_W-1:0] rom [N];
  for (genvar gx = 0; gx < N; gx++) begin : g_rom
    assign rom[gx] = OUT_W'(quarter_sine(gx));
  end

  // Stage 0: accumulator and tuning-word handshake
  logic [PHASE_W-1:0] phase, ftw_active, ftw_pending;
  logic               pend_flag, carry0, valid0;
  logic [PHASE_W:0]   sum_w;

  assign sum_w = {1'b0, phase} + {1'b0, ftw_active};

  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= '0;
      ftw_active  <= '0;
      ftw_pending <= '0;
      pend_flag   <= 1'b0;
      carry0      <= 1'b0;
      valid0      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so the apply test below sees the pending
      // word from before this edge and a coincident load stays pending.
      valid0 <= en;
      carry0 <= en & sum_w[PHASE_W];
      if (en) phase <= sum_w[PHASE_W-1:0];
      if (pend_flag && (ftw_active == '0 || (en && sum_w[PHASE_W]))) begin
        ftw_active <= ftw_pending;
        pend_flag  <= 1'b0;
      end
      if (ftw_load) begin
        ftw_pending <= ftw_in;
        pend_flag   <= 1'b1;
      end
    end
  end

  // Stage 1: capture the phase fields the output mappers need
  logic              s1_valid, s1_carry;
  logic [1:0]        s1_q;
  logic [LUT_AW-1:0] s1_i;
  logic [OUT_W:0]    s1_hi;
  mode_t             s1_mode;

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= valid0;
  end

  // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (valid0) begin
      s1_q     <= phase[PHASE_W-1 -: 2];
      s1_i     <= phase[PHASE_W-3 -: LUT_AW];
      s1_hi    <= phase[PHASE_W-1 -: OUT_W+1];
      s1_mode  <= mode_t'(mode);
      s1_carry <= carry0;
    end
  end

  logic [LUT_AW:0]  rom_addr;
  logic [OUT_W-1:0] q_val, sample_next;

  assign rom_addr = s1_q[0] ? (QTR - {1'b0, s1_i}) : {1'b0, s1_i};
  assign q_val    = rom[rom_addr];

  always_comb begin
    // NOTE: default first so no path through the case can infer a latch.
    sample_next = MID;
    unique case (s1_mode)
      MODE_SINE:   sample_next = s1_q[1] ? (MID - q_val) : (MID + q_val);
      MODE_SAW:    sample_next = s1_hi[OUT_W:1];
      MODE_SQUARE: sample_next = s1_hi[OUT_W] ? '0 : '1;
      MODE_TRI:    sample_next = s1_hi[OUT_W] ? ~s1_hi[OUT_W-1:0] : s1_hi[OUT_W-1:0];
      default:     sample_next = MID;
    endcase
  end

  // Stage 2: output register; sig holds between valid samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sig       <= MID;
      sig_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      sig_valid <= s1_valid;
      wrap      <= s1_valid & s1_carry;
      if (s1_valid) sig <= sample_next;
    end
  end

endmodule
